// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states and stall-vector constants for the memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
   localparam int STALL_W = 5;
   localparam logic [STALL_W-1:0] STALL_ALL   = 5'b11111;
   localparam logic [STALL_W-1:0] STALL_FRONT = 5'b00011;
   localparam logic [STALL_W-1:0] STALL_NONE  = 5'b00000;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_port_arbiter_watchdog: counts bus cycles without ready and flags expiry
//   clk, rst : clock, async active-high reset
//   enable   : bus cycle elapsed without ready
//   clear    : restart count (transaction accepted)
//   expired  : this cycle is the TIMEOUT-th cycle without ready
module mem_port_arbiter_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;
   assign expired = enable && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data access, drives pipeline stalls
//   i_ifReq/i_ifAddr/i_flush -> o_ifInst/o_ifValid      : instruction fetch port
//   i_dataRead/i_dataWrite/i_dataAddr/i_dataSel/i_dataWData -> o_dataRData/o_dataValid : data port
//   o_busEnable/o_busWrite/o_busAddr/o_busSel/o_busWData, i_busRData/i_busReady : external bus
//   o_stall : [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB ; o_busError : sticky timeout
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_ifReq,
   input  logic [31:0]        i_ifAddr,
   input  logic               i_flush,
   output logic [31:0]        o_ifInst,
   output logic               o_ifValid,
   input  logic               i_dataRead,
   input  logic               i_dataWrite,
   input  logic [31:0]        i_dataAddr,
   input  logic [3:0]         i_dataSel,
   input  logic [31:0]        i_dataWData,
   output logic [31:0]        o_dataRData,
   output logic               o_dataValid,
   output logic               o_busEnable,
   output logic               o_busWrite,
   output logic [31:0]        o_busAddr,
   output logic [3:0]         o_busSel,
   output logic [31:0]        o_busWData,
   input  logic [31:0]        i_busRData,
   input  logic               i_busReady,
   output logic [STALL_W-1:0] o_stall,
   output logic               o_busError
);
   state_t state, state_nx;
   logic   discard, expired;
   logic   data_req, busy, accept, done;
   assign data_req = i_dataRead | i_dataWrite;
   assign busy     = state == FETCH || state == DATA;
   assign accept   = state == IDLE && (data_req || i_ifReq);
   assign done     = busy && (i_busReady || expired);
   mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk(clk), .rst(rst), .enable(busy && !i_busReady), .clear(accept), .expired(expired)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (data_req ? DATA : i_ifReq ? FETCH : IDLE) :
                 state == RESP ? IDLE : done ? RESP : state;
      o_stall  = (o_ifValid || o_dataValid) ? STALL_NONE :
                 data_req ? STALL_ALL : i_ifReq ? STALL_FRONT : STALL_NONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         o_busEnable <= 1'b0;
         o_busWrite  <= 1'b0;
         o_busAddr   <= '0;
         o_busSel    <= '0;
         o_busWData  <= '0;
         o_ifInst    <= '0;
         o_ifValid   <= 1'b0;
         o_dataRData <= '0;
         o_dataValid <= 1'b0;
         o_busError  <= 1'b0;
         discard     <= 1'b0;
      end else begin
         o_ifValid   <= 1'b0;
         o_dataValid <= 1'b0;
         if (accept) begin
            o_busEnable <= 1'b1;
            o_busWrite  <= data_req & i_dataWrite;
            o_busAddr   <= data_req ? i_dataAddr : i_ifAddr;
            o_busSel    <= data_req ? i_dataSel : 4'hF;
            o_busWData  <= data_req ? i_dataWData : '0;
            discard     <= !data_req && i_flush;
         end
         if (state == FETCH && i_flush) discard <= 1'b1;
         if (done) begin
            o_busEnable <= 1'b0;
            o_busWrite  <= 1'b0;
            o_busAddr   <= '0;
            o_busSel    <= '0;
            o_busWData  <= '0;
            // a timed-out read returns zero so the core sees a NOP / zero load
            if (state == FETCH) begin
               o_ifInst  <= i_busReady ? i_busRData : '0;
               o_ifValid <= !(discard || i_flush);
            end else begin
               if (!o_busWrite) o_dataRData <= i_busReady ? i_busRData : '0;
               o_dataValid <= 1'b1;
            end
            if (!i_busReady) o_busError <= 1'b1;
         end
         if (state == RESP) discard <= 1'b0;
      end
endmodule
